// File: rtl/single_neuron_pkg.sv
// single_neuron_pkg: default widths and the saturating clamp shared by the neuron datapath
package single_neuron_pkg;

    localparam int X_W = 2;
    localparam int W_W = 2;
    localparam int B_W = 4;
    localparam int Y_W = 4;

    typedef struct packed {
        logic signed [31:0] val;
        logic               flag;
    } clamp_t;

    // Clamp a signed value into the range of a width-bit two's complement number
    function automatic clamp_t sat_clamp(input int value, input int width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -hi - 1;
        sat_clamp.val  = value > hi ? hi : (value < lo ? lo : value);
        sat_clamp.flag = (value > hi) || (value < lo);
    endfunction

endpackage

// File: rtl/single_neuron_mac.sv
// neuron_mac: stage 1 of the neuron, registers the full-width signed product x*w and the bias
module neuron_mac
    import single_neuron_pkg::*;
#(
    parameter int X_W = single_neuron_pkg::X_W,
    parameter int W_W = single_neuron_pkg::W_W,
    parameter int B_W = single_neuron_pkg::B_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic signed [X_W-1:0]     i_x,
    input  logic signed [W_W-1:0]     i_w,
    input  logic signed [B_W-1:0]     i_b,
    output logic signed [X_W+W_W-1:0] o_p,
    output logic signed [B_W-1:0]     o_b,
    output logic                      o_v
);

    localparam int P_W = X_W + W_W;

    logic signed [P_W-1:0] r_p;
    logic signed [B_W-1:0] r_b;
    logic                  r_v;

    // Capture product and bias on valid samples; the valid bit follows in_valid every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p <= '0;
            r_b <= '0;
            r_v <= 1'b0;
        end else begin
            r_v <= i_valid;
            if (i_valid) begin
                r_p <= P_W'(i_x) * P_W'(i_w);
                r_b <= i_b;
            end
        end
    end

    assign o_p = r_p;
    assign o_b = r_b;
    assign o_v = r_v;

endmodule

// File: rtl/single_neuron.sv
// single_neuron: y = sat(x*w + b) over a two-stage pipeline; SINGLE_NEURON_RELU_EN adds ReLU
module single_neuron
    import single_neuron_pkg::*;
#(
    parameter int X_W = single_neuron_pkg::X_W,
    parameter int W_W = single_neuron_pkg::W_W,
    parameter int B_W = single_neuron_pkg::B_W,
    parameter int Y_W = single_neuron_pkg::Y_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic signed [X_W-1:0] x,
    input  logic signed [W_W-1:0] w,
    input  logic signed [B_W-1:0] b,
    output logic                  out_valid,
    output logic signed [Y_W-1:0] y,
    output logic                  sat
);

    localparam int P_W = X_W + W_W;
    localparam int S_W = (P_W > B_W ? P_W : B_W) + 1;

    logic signed [P_W-1:0] w_p;
    logic signed [B_W-1:0] w_b;
    logic                  w_v1;
    logic signed [S_W-1:0] w_s;
    clamp_t                w_c;
    logic signed [Y_W-1:0] w_y;
    logic                  w_sat;
    logic                  w_unused;

    neuron_mac #(
        .X_W(X_W),
        .W_W(W_W),
        .B_W(B_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .i_valid(in_valid),
        .i_x    (x),
        .i_w    (w),
        .i_b    (b),
        .o_p    (w_p),
        .o_b    (w_b),
        .o_v    (w_v1)
    );

    // One bit wider than the widest operand, so the sum never wraps
    assign w_s = S_W'(w_p) + S_W'(w_b);
    assign w_c = sat_clamp(int'(w_s), Y_W);
    // Upper bits of the clamped value are pure sign extension once clamped to Y_W
    assign w_unused = ^w_c.val[31:Y_W];

`ifdef SINGLE_NEURON_RELU_EN
    assign w_y   = w_c.val[Y_W-1] ? '0 : w_c.val[Y_W-1:0];
    assign w_sat = w_c.flag | w_c.val[Y_W-1];
`else
    assign w_y   = w_c.val[Y_W-1:0];
    assign w_sat = w_c.flag;
`endif

    // Stage 2 output register; y/sat hold their last value across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= w_v1;
            if (w_v1) begin
                y   <= w_y;
                sat <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_single_neuron.sv
// tb_single_neuron: randomized and directed checks of single_neuron against an arithmetic reference model
module tb_single_neuron;

    typedef struct {
        logic       v;
        logic [3:0] y;
        logic       s;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [1:0] x = '0;
    logic signed [1:0] w = '0;
    logic signed [3:0] b = '0;
    logic              out_valid;
    logic signed [3:0] y;
    logic              sat;

    int         vectors = 0;
    int         miscompares = 0;
    int         nstep = 0;
    ent_t       q[$];
    logic [3:0] last_y = '0;
    logic       last_s = 1'b0;

    single_neuron dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .x        (x),
        .w        (w),
        .b        (b),
        .out_valid(out_valid),
        .y        (y),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    function automatic ent_t model(input int xi, input int wi, input int bi);
        ent_t e;
        int   s;
        s   = xi * wi + bi;
        e.s = (s > 7) || (s < -8);
        s   = s > 7 ? 7 : (s < -8 ? -8 : s);
`ifdef SINGLE_NEURON_RELU_EN
        if (s < 0) begin
            s   = 0;
            e.s = 1'b1;
        end
`endif
        e.v = 1'b1;
        e.y = 4'(s);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] ex);
        vectors++;
        assert (obs === ex) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, nstep, obs, ex);
        end
    endtask

    task automatic step(input logic r, input logic v, input int xi, input int wi, input int bi);
        ent_t e;
        ent_t ex;
        @(negedge clk);
        nstep++;
        rst      = r;
        in_valid = v;
        x        = 2'(xi);
        w        = 2'(wi);
        b        = 4'(bi);
        if (r) begin
            q.delete();
            q.push_back('{1'b0, 4'd0, 1'b0});
            ex     = '{1'b0, 4'd0, 1'b0};
            last_y = '0;
            last_s = 1'b0;
        end else begin
            e   = model(int'(x), int'(w), int'(b));
            e.v = v;
            q.push_back(e);
            ex = q.pop_front();
            if (ex.v) begin
                last_y = ex.y;
                last_s = ex.s;
            end else begin
                ex.y = last_y;
                ex.s = last_s;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 4'(out_valid), 4'(ex.v));
        chk("y", y, ex.y);
        chk("sat", 4'(sat), 4'(ex.s));
    endtask

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        step(0, 1, 3, 1, 0);
        step(0, 1, 4, 0, 1);
        step(0, 1, 0, 1, 1);
        step(0, 1, -1, 1, -3);
        step(0, 1, -2, -2, 7);
        step(0, 1, -2, 1, -8);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 2);
        step(0, 1, -1, 1, -3);
        step(0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 80; i++)
            step(0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        step(0, 1, 1, 1, 2);
        step(0, 1, -2, -2, 7);
        step(1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, -2, 1, -8);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
